// File: rtl/inst_axi_rd_bridge.sv
// Read-only bridge from the IF stage SRAM-like instruction port to a single-ID AXI3 AR/R channel.
// Optional performance counters are enabled by defining INST_AXI_BRIDGE_PERF_EN.
module inst_axi_rd_bridge #(
  parameter int         MAX_OUTST = 2,
  parameter logic [3:0] AXI_ARID  = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] perf_req_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic {AR_IDLE = 1'b0, AR_BUSY = 1'b1} ar_state_t;

  localparam logic [1:0] OUTST_LIMIT = 2'(MAX_OUTST);

  ar_state_t   ar_state;
  ar_state_t   ar_state_nxt;
  logic [1:0]  outst;
  logic        accept;
  logic        r_hs;
  logic [31:0] araddr_p0;
  logic [1:0]  size_p0;
  logic [31:0] rdata_p1;
  logic        vld_p1;
  logic        unused_ok;

  // Single ID and in-order slave: beat id, last flag and response carry no extra information.
  assign unused_ok = ^{inst_sram_wstrb, inst_sram_wdata, inst_sram_addr[1:0], rid, rlast, rresp};

  assign inst_sram_addr_ok = inst_sram_req && !inst_sram_wr && (ar_state == AR_IDLE) &&
                             (outst < OUTST_LIMIT) && !reset;
  assign accept = inst_sram_req && inst_sram_addr_ok;
  assign rready = (outst != 2'd0);
  assign r_hs   = rvalid && rready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state <= AR_IDLE;
    end else begin
      ar_state <= ar_state_nxt;
    end
  end

  always_comb begin
    ar_state_nxt = ar_state;
    arvalid      = 1'b0;
    case (ar_state)
      AR_IDLE: begin
        if (accept) ar_state_nxt = AR_BUSY;
      end
      AR_BUSY: begin
        arvalid = 1'b1;
        if (arready) ar_state_nxt = AR_IDLE;
      end
      default: ar_state_nxt = AR_IDLE;
    endcase
  end

  // p0: request latched into the AR channel registers
  always_ff @(posedge clk) begin
    if (reset) begin
      araddr_p0 <= 32'd0;
      size_p0   <= 2'd0;
    end else if (accept) begin
      araddr_p0 <= {inst_sram_addr[31:2], 2'b00};
      size_p0   <= inst_sram_size;
    end
  end

  // Outstanding count drops only when the CPU actually sees the data, not at the R handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      outst <= 2'd0;
    end else begin
      case ({accept, vld_p1})
        2'b10:   outst <= outst + 2'd1;
        2'b01:   outst <= outst - 2'd1;
        default: outst <= outst;
      endcase
    end
  end

  // p1: R beat captured, returned to the IF stage one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= 32'd0;
    end else begin
      vld_p1 <= r_hs;
      if (r_hs) rdata_p1 <= rdata;
    end
  end

  assign inst_sram_data_ok = vld_p1;
  assign inst_sram_rdata   = rdata_p1;

  assign arid    = AXI_ARID;
  assign araddr  = araddr_p0;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_p0};
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

`ifdef INST_AXI_BRIDGE_PERF_EN
  logic [31:0] req_cnt_q;
  logic [31:0] stall_cnt_q;

  // Write requests are never counted as stalls; they are simply never accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_cnt_q   <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (accept) req_cnt_q <= req_cnt_q + 32'd1;
      if (inst_sram_req && !inst_sram_wr && !inst_sram_addr_ok) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_req_cnt   = req_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_req_cnt   = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
